// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: register map and edge-select encodings shared by the GPIO bank.
package gpio_bank_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_DIR       = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR    = 3'd5;
    localparam logic [2:0] ADDR_BLINKMASK = 3'd6;
    localparam logic [2:0] ADDR_BLINKPER  = 3'd7;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/gpio_bank_sync.sv
// gpio_bank_sync: pad input synchroniser, one-cycle history flop, arming
// counter and per-bit edge detect. Edges are masked until the chain has
// flushed after reset so pad levels present at reset never look like edges.
module gpio_bank_sync
    import gpio_bank_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_RISING,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_det
);

    localparam int ARM_COUNT = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  in_prev;
    logic [2:0]                        arm_cnt;
    logic                              armed;
    logic [WIDTH-1:0]                  edge_raw;

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign armed   = (arm_cnt == 3'(ARM_COUNT));

    // Synchroniser chain, history flop and saturating arming counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            in_prev <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            in_prev <= in_sync;
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

    // Raw edge selection for the configured polarity.
    always_comb begin
        edge_raw = in_sync & ~in_prev;
        if (EDGE_TYPE == EDGE_FALLING) begin
            edge_raw = ~in_sync & in_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_raw = in_sync ^ in_prev;
        end
    end

    assign edge_det = edge_raw & {WIDTH{armed}};

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with direction control, atomic set/clear,
// sticky edge capture and a level interrupt.
// Optional blink generator enabled by defining GPIO_BANK_BLINK_EN; without it
// addresses 6/7 read 0 and ignore writes.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_det;
    logic             irq_q;

    assign wr_en     = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign edge_clr  = (wr_en && address == ADDR_EDGECAP) ? wd : '0;

    gpio_bank_sync #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .gpio_in  (gpio_in),
        .in_sync  (in_sync),
        .edge_det (edge_det)
    );

    // Output data register: plain write, atomic set and atomic clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_out <= wd;
                ADDR_OUTSET: data_out <= data_out | wd;
                ADDR_OUTCLR: data_out <= data_out & ~wd;
                default:     data_out <= data_out;
            endcase
        end
    end

    // Direction and interrupt mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir     <= '0;
            irqmask <= '0;
        end else if (wr_en) begin
            if (address == ADDR_DIR)     dir     <= wd;
            if (address == ADDR_IRQMASK) irqmask <= wd;
        end
    end

    // Sticky edge capture; a fresh edge overrides a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~edge_clr) | edge_det;
        end
    end

    // Registered interrupt, one cycle behind the capture register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(edgecap & irqmask);
        end
    end

    assign irq     = irq_q;
    assign gpio_oe = dir;

`ifdef GPIO_BANK_BLINK_EN
    logic [WIDTH-1:0] blink_mask;
    logic [31:0]      blink_per;
    logic [31:0]      blink_cnt;
    logic             blink_phase;

    // Blink generator: count 0..blink_per then wrap and toggle the phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask  <= '0;
            blink_per   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_BLINKMASK) begin
                blink_mask <= wd;
            end
            if (wr_en && address == ADDR_BLINKPER) begin
                blink_per   <= writedata;
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_per == 32'd0) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt >= blink_per) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end
    end

    assign gpio_out = data_out ^ (blink_mask & {WIDTH{blink_phase}});
`else
    assign gpio_out = data_out;
`endif

    // Combinational read mux, zero-extended to the bus width.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata = 32'((dir & data_out) | (~dir & in_sync));
            ADDR_DIR:       readdata = 32'(dir);
            ADDR_IRQMASK:   readdata = 32'(irqmask);
            ADDR_EDGECAP:   readdata = 32'(edgecap);
`ifdef GPIO_BANK_BLINK_EN
            ADDR_BLINKMASK: readdata = 32'(blink_mask);
            ADDR_BLINKPER:  readdata = blink_per;
`endif
            default:        readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: scoreboard bench for gpio_bank (WIDTH=8, RESET_VALUE=A5,
// rising edges, two synchroniser stages).
module tb_gpio_bank;
    import gpio_bank_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd;

    gpio_bank #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .EDGE_TYPE   (EDGE_RISING),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .gpio_oe    (gpio_oe),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_value("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_value(e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic peek(input logic [2:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: writes during reset must not land.
        reset_n = 1'b0;
        gpio_in = 8'h00;
        tick(2);
        wr(ADDR_DATA, 32'h00);
        wr(ADDR_DIR, 32'hFF);
        sb_push("rst_gpio_out", 32'hA5);
        sb_push("rst_gpio_oe", 32'h00);
        sb_push("rst_irq", 32'h0);
        sb_pop(32'(gpio_out));
        sb_pop(32'(gpio_oe));
        sb_pop(32'(irq));

        @(negedge clk);
        reset_n = 1'b1;
        tick(1);

        // Output data path readback with all pins driven.
        wr(ADDR_DIR, 32'hFF);
        sb_push("data_rd_reset", 32'hA5);
        sb_push("oe_all", 32'hFF);
        peek(ADDR_DATA, rd);
        sb_pop(rd);
        sb_pop(32'(gpio_oe));

        wr(ADDR_DATA, 32'hFFFF_FF0F);
        sb_push("out_data", 32'h0F);
        sb_pop(32'(gpio_out));
        wr(ADDR_OUTSET, 32'h30);
        sb_push("out_set", 32'h3F);
        sb_pop(32'(gpio_out));
        wr(ADDR_OUTCLR, 32'h03);
        sb_push("out_clr", 32'h3C);
        sb_push("rd_outset", 32'h0);
        sb_push("rd_outclr", 32'h0);
        sb_push("rd_data_3c", 32'h3C);
        sb_pop(32'(gpio_out));
        peek(ADDR_OUTSET, rd);
        sb_pop(rd);
        peek(ADDR_OUTCLR, rd);
        sb_pop(rd);
        peek(ADDR_DATA, rd);
        sb_pop(rd);

        // Mixed direction: low nibble from data_out, high nibble from pads.
        wr(ADDR_DIR, 32'h0F);
        gpio_in = 8'hA0;
        sb_push("rd_data_mixed", 32'hAC);
        sb_push("edgecap_a0", 32'hA0);
        sb_push("irq_masked", 32'h0);
        tick(4);
        peek(ADDR_DATA, rd);
        sb_pop(rd);
        peek(ADDR_EDGECAP, rd);
        sb_pop(rd);
        sb_pop(32'(irq));
        wr(ADDR_EDGECAP, 32'hFF);
        sb_push("edgecap_clr_all", 32'h00);
        peek(ADDR_EDGECAP, rd);
        sb_pop(rd);

        // Falling edges are not captured with rising-edge detection.
        gpio_in = 8'h00;
        sb_push("no_fall_capture", 32'h00);
        tick(4);
        peek(ADDR_EDGECAP, rd);
        sb_pop(rd);

        // Capture latency and interrupt timing on bit 0.
        wr(ADDR_IRQMASK, 32'h01);
        @(negedge clk);
        gpio_in = 8'h01;
        address = ADDR_EDGECAP;
        sb_push("ec_pre", 32'h00);
        sb_push("ec_set", 32'h01);
        sb_push("irq_lag", 32'h0);
        sb_push("irq_set", 32'h1);
        tick(1);
        tick(1);
        sb_pop(readdata);
        tick(1);
        sb_pop(readdata);
        sb_pop(32'(irq));
        tick(1);
        sb_pop(32'(irq));
        wr(ADDR_EDGECAP, 32'h01);
        sb_push("ec_cleared", 32'h00);
        sb_push("irq_cleared", 32'h0);
        peek(ADDR_EDGECAP, rd);
        sb_pop(rd);
        tick(1);
        sb_pop(32'(irq));

        // Edge and clear in the same cycle: the edge wins.
        @(negedge clk);
        gpio_in = 8'h00;
        tick(4);
        @(negedge clk);
        gpio_in = 8'h01;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        address    = ADDR_EDGECAP;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h01;
        sb_push("collision_edge_wins", 32'h01);
        sb_push("collision_irq", 32'h1);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        peek(ADDR_EDGECAP, rd);
        sb_pop(rd);
        tick(1);
        sb_pop(32'(irq));
        wr(ADDR_EDGECAP, 32'hFF);

        // Reset with pads high: no spurious capture after release.
        @(negedge clk);
        reset_n = 1'b0;
        gpio_in = 8'hFF;
        sb_push("rst2_gpio_out", 32'hA5);
        sb_push("rst2_gpio_oe", 32'h00);
        sb_push("rst2_irq", 32'h0);
        sb_push("rst2_edgecap", 32'h00);
        tick(2);
        sb_pop(32'(gpio_out));
        sb_pop(32'(gpio_oe));
        sb_pop(32'(irq));
        peek(ADDR_EDGECAP, rd);
        sb_pop(rd);
        for (int i = 0; i < 20; i++) sb_push($sformatf("arm_quiet_%0d", i), 32'h00);
        sb_push("rd_pads_high", 32'hFF);
        address = ADDR_EDGECAP;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            sb_pop(readdata);
        end
        peek(ADDR_DATA, rd);
        sb_pop(rd);

`ifdef GPIO_BANK_BLINK_EN
        wr(ADDR_DATA, 32'h00);
        wr(ADDR_BLINKMASK, 32'h01);
        wr(ADDR_BLINKPER, 32'h3);
        for (int j = 0; j < 14; j++) sb_push($sformatf("blink_%0d", j), 32'((j / 4) % 2));
        for (int j = 0; j < 14; j++) begin
            sb_pop(32'(gpio_out[0]));
            if (j != 13) tick(1);
        end
        wr(ADDR_BLINKPER, 32'h0);
        for (int j = 0; j < 8; j++) sb_push($sformatf("blink_frozen_%0d", j), 32'h0);
        for (int j = 0; j < 8; j++) begin
            sb_pop(32'(gpio_out[0]));
            tick(1);
        end
        sb_push("rd_blinkmask", 32'h01);
        peek(ADDR_BLINKMASK, rd);
        sb_pop(rd);
`else
        wr(ADDR_BLINKMASK, 32'hFF);
        wr(ADDR_BLINKPER, 32'h3);
        sb_push("rd_addr6_absent", 32'h0);
        sb_push("rd_addr7_absent", 32'h0);
        sb_push("out_no_blink", 32'hA5);
        peek(ADDR_BLINKMASK, rd);
        sb_pop(rd);
        peek(ADDR_BLINKPER, rd);
        sb_pop(rd);
        tick(6);
        sb_pop(32'(gpio_out));
`endif

        check_value("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
